eight_dice: RTL and testbench

- Drives a 3x3 (nine-segment) LED dot matrix as an eight-valued die. The 3-bit input s (0..7) selects a face of s+1 pips.
- The matrix is scanned one row at a time. row selects the lit row; col gives that row's column pattern.
- Sits between the die-value logic and the LED matrix pins.

---
 rtl/eight_dice_if.sv | 10 +
 rtl/eight_dice.sv | 103 ++++++++++
 tb/tb_eight_dice.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/eight_dice_if.sv
// Die-value input and scanned row/column outputs between the die logic and the LED matrix.
// The master drives the die value; the slave (eight_dice) drives the matrix pins.
interface eight_dice_if;
  logic [2:0] s;
  logic [2:0] row;
  logic [2:0] col;

  modport master (output s, input row, input col);
  modport slave  (input s, output row, output col);
endinterface

// File: rtl/eight_dice.sv
// Row-scanned 3x3 LED driver showing an eight-valued die face of s+1 pips.
// The die value is latched once per frame, so a frame never mixes two faces.
module eight_dice #(
  parameter int unsigned SCAN_DIV   = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  eight_dice_if.slave dice
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ROW_TOP = 2'd0,
    ROW_MID = 2'd1,
    ROW_BOT = 2'd2
  } row_e;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_cnt_next;
  row_e             row_idx;
  row_e             row_idx_next;
  logic [2:0]       face_q;
  logic [2:0]       face_next;
  logic [2:0]       row_q;
  logic [2:0]       row_next;
  logic [2:0]       col_q;
  logic [2:0]       col_next;
  logic             tick;

  // Pip layout per face, packed as {row0, row1, row2} with bit 2 = right column.
  function automatic logic [2:0] face_row(input logic [2:0] face, input row_e r);
    logic [8:0] pat;
    pat = 9'b000_000_000;
    case (face)
      3'd0: pat = 9'b000_010_000;
      3'd1: pat = 9'b001_000_100;
      3'd2: pat = 9'b001_010_100;
      3'd3: pat = 9'b101_000_101;
      3'd4: pat = 9'b101_010_101;
      3'd5: pat = 9'b101_101_101;
      3'd6: pat = 9'b101_111_101;
      3'd7: pat = 9'b111_101_111;
      default: pat = 9'b000_000_000;
    endcase
    case (r)
      ROW_TOP: return pat[8:6];
      ROW_MID: return pat[5:3];
      default: return pat[2:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      row_idx <= ROW_TOP;
      face_q  <= 3'b000;
      row_q   <= 3'b000;
      col_q   <= 3'b000;
    end else begin
      div_cnt <= div_cnt_next;
      row_idx <= row_idx_next;
      face_q  <= face_next;
      row_q   <= row_next;
      col_q   <= col_next;
    end
  end

  // Outputs are built from pre-edge row/face, so the pins trail the scanner by one cycle.
  always_comb begin
    tick         = (div_cnt == DIV_LAST);
    div_cnt_next = tick ? '0 : div_cnt + 1'b1;
    row_idx_next = row_idx;
    face_next    = face_q;
    row_next     = 3'b000;
    col_next     = face_row(face_q, row_idx);

    if (tick) begin
      case (row_idx)
        ROW_TOP: row_idx_next = ROW_MID;
        ROW_MID: row_idx_next = ROW_BOT;
        ROW_BOT: begin
          row_idx_next = ROW_TOP;
          face_next    = dice.s;
        end
        default: row_idx_next = ROW_TOP;
      endcase
    end

    case (row_idx)
      ROW_TOP: row_next = 3'b001;
      ROW_MID: row_next = 3'b010;
      ROW_BOT: row_next = 3'b100;
      default: row_next = 3'b001;
    endcase
  end

  assign dice.row = row_q ^ {3{ACTIVE_LOW}};
  assign dice.col = col_q ^ {3{ACTIVE_LOW}};

endmodule

// File: tb/tb_eight_dice.sv
// Self-checking bench for eight_dice: three instances cover fast scan, divided scan and active-low pins.
module tb_eight_dice;

  typedef struct packed {
    logic       rst;
    logic [2:0] s;
    logic [2:0] row;
    logic [2:0] col;
  } vec_t;

  typedef struct {
    int         dut;
    logic [2:0] row;
    logic [2:0] col;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  logic rst_c;

  eight_dice_if if_a ();
  eight_dice_if if_b ();
  eight_dice_if if_c ();

  eight_dice #(.SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .reset(rst_a), .dice(if_a.slave));
  eight_dice #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut_b (.clk(clk), .reset(rst_b), .dice(if_b.slave));
  eight_dice #(.SCAN_DIV(1), .ACTIVE_LOW(1'b1)) dut_c (.clk(clk), .reset(rst_c), .dice(if_c.slave));

  // Reference pip layout, {row0,row1,row2}, bit 2 of each row = right column.
  logic [8:0] face_tbl [8] = '{
    9'b000_010_000, 9'b001_000_100, 9'b001_010_100, 9'b101_000_101,
    9'b101_010_101, 9'b101_101_101, 9'b101_111_101, 9'b111_101_111
  };

  exp_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_c[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [2:0] exp_col(input int f, input int r);
    logic [8:0] p;
    p = face_tbl[f];
    return p[8-3*r -: 3];
  endfunction

  task automatic checkOutput();
    exp_t       e;
    logic [2:0] ar;
    logic [2:0] ac;
    e = sb.pop_front();
    case (e.dut)
      0:       begin ar = if_a.row; ac = if_a.col; end
      1:       begin ar = if_b.row; ac = if_b.col; end
      default: begin ar = if_c.row; ac = if_c.col; end
    endcase
    checks++;
    if (ar !== e.row || ac !== e.col) begin
      errors++;
      $display("[TB] FAIL %s: got row=%b col=%b, expected row=%b col=%b", e.tag, ar, ac, e.row, e.col);
    end
  endtask

  task automatic applyStimulus(input int d, input logic r, input logic [2:0] sv,
                               input logic [2:0] er, input logic [2:0] ec, input string tag);
    exp_t e;
    case (d)
      0:       begin rst_a = r; if_a.s = sv; end
      1:       begin rst_b = r; if_b.s = sv; end
      default: begin rst_c = r; if_c.s = sv; end
    endcase
    e.dut = d;
    e.row = er;
    e.col = ec;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // One frame on the SCAN_DIV=1 active-high instance, s held, showing the given face.
  task automatic runFrame(input logic [2:0] sv, input int face, input string tag);
    for (int r = 0; r < 3; r++)
      applyStimulus(0, 1'b0, sv, 3'(3'b001 << r), exp_col(face, r), $sformatf("%s_r%0d", tag, r));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.s = 3'd0; if_b.s = 3'd0; if_c.s = 3'd0;

    tbl_a.push_back({1'b1, 3'd5, 3'b000, 3'b000});
    tbl_a.push_back({1'b1, 3'd5, 3'b000, 3'b000});
    tbl_a.push_back({1'b0, 3'd5, 3'b001, 3'b000});
    tbl_a.push_back({1'b0, 3'd6, 3'b010, 3'b010});
    tbl_a.push_back({1'b0, 3'd7, 3'b100, 3'b000});
    for (int k = 0; k < 2; k++) begin
      tbl_a.push_back({1'b0, 3'd7, 3'b001, 3'b111});
      tbl_a.push_back({1'b0, 3'd7, 3'b010, 3'b101});
      tbl_a.push_back({1'b0, 3'd7, 3'b100, 3'b111});
    end

    tbl_c.push_back({1'b1, 3'd0, 3'b111, 3'b111});
    tbl_c.push_back({1'b1, 3'd0, 3'b111, 3'b111});
    for (int k = 0; k < 2; k++) begin
      tbl_c.push_back({1'b0, 3'd0, 3'b110, 3'b111});
      tbl_c.push_back({1'b0, 3'd0, 3'b101, 3'b101});
      tbl_c.push_back({1'b0, 3'd0, 3'b011, 3'b111});
    end

    foreach (tbl_a[i])
      applyStimulus(0, tbl_a[i].rst, tbl_a[i].s, tbl_a[i].row, tbl_a[i].col, $sformatf("vec_a%0d", i));

    begin
      int prev;
      prev = 7;
      for (int v = 0; v < 8; v++) begin
        runFrame(3'(v), prev, $sformatf("sweep_s%0d_f0", v));
        runFrame(3'(v), v, $sformatf("sweep_s%0d_f1", v));
        prev = v;
      end
    end

    runFrame(3'd2, 7, "pre_mid");
    applyStimulus(0, 1'b0, 3'd2, 3'b001, 3'b001, "mid_r0");
    applyStimulus(0, 1'b0, 3'd5, 3'b010, 3'b010, "mid_r1");
    applyStimulus(0, 1'b0, 3'd5, 3'b100, 3'b100, "mid_r2");
    runFrame(3'd5, 5, "after_mid");

    applyStimulus(0, 1'b0, 3'd6, 3'b001, 3'b101, "glitch_r0");
    applyStimulus(0, 1'b0, 3'd1, 3'b010, 3'b101, "glitch_r1");
    applyStimulus(0, 1'b0, 3'd3, 3'b100, 3'b101, "glitch_r2");
    runFrame(3'd3, 3, "after_glitch");

    rst_a = 1'b1;
    applyStimulus(1, 1'b1, 3'd3, 3'b000, 3'b000, "div_reset0");
    applyStimulus(1, 1'b1, 3'd3, 3'b000, 3'b000, "div_reset1");
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 4; k++)
          if (!(f == 1 && r == 2 && k >= 2))
            applyStimulus(1, 1'b0, 3'd3, 3'(3'b001 << r), exp_col((f == 0) ? 0 : 3, r),
                          $sformatf("div_f%0d_r%0d_k%0d", f, r, k));
    applyStimulus(1, 1'b1, 3'd6, 3'b000, 3'b000, "div_mid_reset");
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        applyStimulus(1, 1'b0, 3'd6, 3'(3'b001 << r), exp_col(0, r), $sformatf("div_restart_r%0d_k%0d", r, k));

    foreach (tbl_c[i])
      applyStimulus(2, tbl_c[i].rst, tbl_c[i].s, tbl_c[i].row, tbl_c[i].col, $sformatf("vec_c%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
